// File: rtl/hazard_pkg.sv
// Shared types and helpers for the dec->exe->writeback hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {HZ_IDLE, HZ_FLUSH} hz_state_e;

  // Counter width is sized for the default writeback depth; it must hold WB_DEPTH+1.
  localparam int unsigned WB_DEPTH_DEF = 3;
  localparam int unsigned SB_W         = $clog2(WB_DEPTH_DEF + 2);

  typedef logic [31:0][SB_W-1:0] sb_vec_t;

  // The final count is the rf write cycle, which dec can already read, so only >1 blocks.
  function automatic logic sb_hit(input logic [4:0] addr, input logic use_en,
                                  input sb_vec_t sb_vec);
    return use_en && (addr != 5'd0) && (sb_vec[addr] > SB_W'(1));
  endfunction

endpackage

// File: rtl/u_hazard_if.sv
// Decode/execute side of the hazard controller: instruction operands, redirect and controls.
interface u_hazard_if #(
  parameter int unsigned CNT_W = 32
);

  logic             dec_valid;
  logic             dec_rs1_use;
  logic [4:0]       dec_rs1_a;
  logic             dec_rs2_use;
  logic [4:0]       dec_rs2_a;
  logic             dec_rd_we;
  logic [4:0]       dec_rd_a;
  logic             exe_branch;
  logic             stall;
  logic             flush0;
  logic             flush1;
  logic [CNT_W-1:0] hz_stall_cnt;
  logic [CNT_W-1:0] hz_flush_cnt;

  modport master (
    output dec_valid, dec_rs1_use, dec_rs1_a, dec_rs2_use, dec_rs2_a, dec_rd_we, dec_rd_a,
    output exe_branch,
    input  stall, flush0, flush1, hz_stall_cnt, hz_flush_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1_use, dec_rs1_a, dec_rs2_use, dec_rs2_a, dec_rd_we, dec_rd_a,
    input  exe_branch,
    output stall, flush0, flush1, hz_stall_cnt, hz_flush_cnt
  );

endinterface

// File: rtl/u_hazard_sb.sv
// Per-register write scoreboard: counts down each in-flight write and flags RAW hits in dec.
module u_hazard_sb
  import hazard_pkg::*;
#(
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       issue,
  input  logic [4:0] rd_a,
  input  logic       dec_valid,
  input  logic       rs1_use,
  input  logic [4:0] rs1_a,
  input  logic       rs2_use,
  input  logic [4:0] rs2_a,
  output logic       raw_hit
);

  localparam logic [SB_W-1:0] SbLoad = SB_W'(WB_DEPTH + 1);
  localparam logic [SB_W-1:0] SbOne  = SB_W'(1);

  sb_vec_t sb_q, sb_d;

  // Entry 0 stays zero: x0 is never tracked.
  always_comb begin
    sb_d = '0;
    for (int r = 1; r < 32; r++) begin
      if (issue && (rd_a == 5'(r))) begin
        sb_d[r] = SbLoad;
      end else if (sb_q[r] != '0) begin
        sb_d[r] = sb_q[r] - SbOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Uses pre-update counts, so an instruction reading its own rd checks older writers only.
  assign raw_hit = dec_valid && (sb_hit(rs1_a, rs1_use, sb_q) || sb_hit(rs2_a, rs2_use, sb_q));

endmodule

// File: rtl/u_hazard.sv
// Hazard controller: RAW stall via scoreboard, wrong-path squash after exe redirects, perf counters.
module u_hazard
  import hazard_pkg::*;
#(
  parameter int unsigned WB_DEPTH  = WB_DEPTH_DEF,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rstn,
  u_hazard_if.slave  bus
);

  localparam int unsigned    FcW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYC - 1);
  localparam logic [FcW-1:0] FcOne  = FcW'(1);

  hz_state_e        state_q, state_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             raw_hit;
  logic             flush;
  logic             stall;
  logic             issue;

  u_hazard_sb #(
    .WB_DEPTH (WB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .issue     (issue),
    .rd_a      (bus.dec_rd_a),
    .dec_valid (bus.dec_valid),
    .rs1_use   (bus.dec_rs1_use),
    .rs1_a     (bus.dec_rs1_a),
    .rs2_use   (bus.dec_rs2_use),
    .rs2_a     (bus.dec_rs2_a),
    .raw_hit   (raw_hit)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      HZ_IDLE: begin
        if (bus.exe_branch && (FLUSH_CYC > 1)) begin
          state_d = HZ_FLUSH;
          fcnt_d  = FcLoad;
        end
      end
      HZ_FLUSH: begin
        // A fresh redirect restarts the squash window.
        if (bus.exe_branch) begin
          fcnt_d = FcLoad;
        end else if (fcnt_q == FcOne) begin
          state_d = HZ_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FcOne;
        end
      end
      default: begin
        state_d = HZ_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Outputs are held low while reset is asserted, regardless of the inputs.
  assign flush = rstn && (bus.exe_branch || (state_q == HZ_FLUSH));
  assign stall = rstn && raw_hit && !flush;
  assign issue = bus.dec_valid && !stall && !flush && bus.dec_rd_we && (bus.dec_rd_a != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HZ_IDLE;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
    end
  end

  assign bus.stall        = stall;
  assign bus.flush0       = flush;
  assign bus.flush1       = flush;
  assign bus.hz_stall_cnt = stall_cnt_q;
  assign bus.hz_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_u_hazard.sv
// Self-checking bench for u_hazard: directed scenarios plus random traffic against a cycle model.
module tb_u_hazard;

  localparam int WB_DEPTH  = 3;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  u_hazard_if #(.CNT_W(CNT_W)) bus ();

  u_hazard #(
    .WB_DEPTH  (WB_DEPTH),
    .FLUSH_CYC (FLUSH_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model: cycle at which each register becomes readable, and last flushed cycle.
  int               cyc;
  int               ready [32];
  int               flush_until;
  logic [CNT_W-1:0] m_stall_cnt;
  logic [CNT_W-1:0] m_flush_cnt;
  logic             exp_stall;
  logic             exp_flush;
  int               n_cmp;
  int               n_fail;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready[i] = 0;
    flush_until = -1;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic model_eval();
    logic raw;
    raw = bus.dec_valid &&
          ((bus.dec_rs1_use && bus.dec_rs1_a != 0 && cyc < ready[bus.dec_rs1_a]) ||
           (bus.dec_rs2_use && bus.dec_rs2_a != 0 && cyc < ready[bus.dec_rs2_a]));
    exp_flush = rstn && (bus.exe_branch || cyc <= flush_until);
    exp_stall = rstn && raw && !exp_flush;
  endtask

  task automatic clk_adv();
    @(posedge clk);
    model_eval();
    if (rstn) begin
      if (exp_stall) m_stall_cnt++;
      if (exp_flush) m_flush_cnt++;
      if (bus.exe_branch) flush_until = cyc + FLUSH_CYC - 1;
      if (bus.dec_valid && !exp_stall && !exp_flush && bus.dec_rd_we && bus.dec_rd_a != 0)
        ready[bus.dec_rd_a] = cyc + WB_DEPTH + 1;
    end else begin
      model_reset();
    end
    cyc++;
    #1;
  endtask

  task automatic set_instr(input logic v, input logic u1, input logic [4:0] a1, input logic u2,
                           input logic [4:0] a2, input logic we, input logic [4:0] rd);
    bus.dec_valid   = v;
    bus.dec_rs1_use = u1;
    bus.dec_rs1_a   = a1;
    bus.dec_rs2_use = u2;
    bus.dec_rs2_a   = a2;
    bus.dec_rd_we   = we;
    bus.dec_rd_a    = rd;
  endtask

  task automatic rand_inputs(input int max_reg, input int br_mod);
    set_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, max_reg)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, max_reg)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, max_reg)));
    bus.exe_branch = ($urandom_range(0, br_mod - 1) == 0);
  endtask

  task automatic drain();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    bus.exe_branch = 1'b0;
    repeat (WB_DEPTH + FLUSH_CYC + 2) clk_adv();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      rand_inputs(31, 2);
      @(negedge clk);
      n_cmp++;
      if ({bus.stall, bus.flush0, bus.flush1} !== 3'b000 ||
          bus.hz_stall_cnt !== '0 || bus.hz_flush_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got stall/f0/f1=%b cnts=%0d/%0d expected 000 0/0",
                 {bus.stall, bus.flush0, bus.flush1}, bus.hz_stall_cnt, bus.hz_flush_cnt);
      end
      clk_adv();
    end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    bus.exe_branch = 1'b0;
    rstn = 1'b1;
    clk_adv();
    @(negedge clk);
    n_cmp++;
    if (bus.hz_stall_cnt !== '0 || bus.hz_flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.hz_stall_cnt,
               bus.hz_flush_cnt);
    end
    clk_adv();
  endtask

  task automatic test_raw_stall();
    logic [CNT_W-1:0] base;
    drain();
    base = m_stall_cnt;
    set_instr(1, 1, 5, 0, 0, 1, 5);  // addi x5,x5,1
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_issue: got stall=%b expected 0", bus.stall);
    end
    clk_adv();
    set_instr(1, 1, 5, 1, 1, 1, 6);  // add x6,x5,x1
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.stall !== (k <= 3)) begin
        n_fail++;
        $display("FAIL raw_stall_t%0d: got stall=%b expected %b", k, bus.stall, (k <= 3));
      end
      clk_adv();
    end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.hz_stall_cnt !== base + 3) begin
      n_fail++;
      $display("FAIL raw_stall_cnt: got %0d expected %0d", bus.hz_stall_cnt, base + 3);
    end
    clk_adv();
  endtask

  task automatic test_x0();
    drain();
    set_instr(1, 0, 0, 0, 0, 1, 0);
    clk_adv();
    set_instr(1, 1, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL x0_no_stall_t%0d: got stall=%b expected 0", k, bus.stall);
      end
      clk_adv();
    end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] base;
    logic [2:0]       br_a;
    logic [2:0]       want_a;
    logic [3:0]       br_b;
    logic [3:0]       want_b;
    drain();
    br_a   = 3'b001;  // bit k = cycle k
    want_a = 3'b011;
    for (int k = 0; k < 3; k++) begin
      bus.exe_branch = br_a[k];
      @(negedge clk);
      n_cmp++;
      if ({bus.flush0, bus.flush1} !== {2{want_a[k]}}) begin
        n_fail++;
        $display("FAIL flush_single_t%0d: got %b expected %b", k, {bus.flush0, bus.flush1},
                 {2{want_a[k]}});
      end
      clk_adv();
    end
    base   = m_flush_cnt;
    br_b   = 4'b0011;
    want_b = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      bus.exe_branch = br_b[k];
      @(negedge clk);
      n_cmp++;
      if ({bus.flush0, bus.flush1} !== {2{want_b[k]}}) begin
        n_fail++;
        $display("FAIL flush_extend_t%0d: got %b expected %b", k, {bus.flush0, bus.flush1},
                 {2{want_b[k]}});
      end
      clk_adv();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.hz_flush_cnt !== base + 3) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected %0d", bus.hz_flush_cnt, base + 3);
    end
    clk_adv();
  endtask

  task automatic test_flush_beats_stall();
    logic [1:0] want [6];
    drain();
    want = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};  // {stall, flush0}
    for (int k = 0; k < 6; k++) begin
      bus.exe_branch = (k == 2);
      case (k)
        0:       set_instr(1, 0, 0, 0, 0, 1, 9);   // writes x9
        1, 2, 3: set_instr(1, 0, 0, 1, 9, 1, 10);  // reads x9, writes x10
        4:       set_instr(1, 0, 0, 1, 9, 0, 0);
        default: set_instr(1, 1, 10, 0, 0, 0, 0);  // x10 must never have been claimed
      endcase
      @(negedge clk);
      n_cmp++;
      if ({bus.stall, bus.flush0} !== want[k]) begin
        n_fail++;
        $display("FAIL flush_vs_stall_t%0d: got %b expected %b", k, {bus.stall, bus.flush0},
                 want[k]);
      end
      clk_adv();
    end
  endtask

  task automatic test_reload_and_reset();
    drain();
    for (int k = 0; k < 7; k++) begin
      if (k == 0 || k == 2) set_instr(1, 0, 0, 0, 0, 1, 7);
      else if (k == 1)      set_instr(0, 0, 0, 0, 0, 0, 0);
      else                  set_instr(1, 1, 7, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (bus.stall !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL reload_t%0d: got stall=%b expected %b", k, bus.stall, (k >= 3 && k <= 5));
      end
      clk_adv();
    end
    drain();
    set_instr(1, 0, 0, 0, 0, 1, 7);
    clk_adv();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    clk_adv();
    set_instr(1, 0, 0, 0, 0, 1, 7);
    clk_adv();
    set_instr(1, 1, 7, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_stall: got %b expected 1", bus.stall);
    end
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.hz_stall_cnt !== '0 || bus.hz_flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got stall=%b cnts=%0d/%0d expected 0 0/0", bus.stall,
               bus.hz_stall_cnt, bus.hz_flush_cnt);
    end
    clk_adv();
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_reader: got stall=%b expected 0", bus.stall);
    end
    clk_adv();
  endtask

  task automatic test_random();
    drain();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(3, 9);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if ({bus.stall, bus.flush0, bus.flush1} !== {exp_stall, exp_flush, exp_flush} ||
          bus.hz_stall_cnt !== m_stall_cnt || bus.hz_flush_cnt !== m_flush_cnt) begin
        n_fail++;
        $display("FAIL random_c%0d: got s/f0/f1=%b cnts=%0d/%0d expected %b %0d/%0d", i,
                 {bus.stall, bus.flush0, bus.flush1}, bus.hz_stall_cnt, bus.hz_flush_cnt,
                 {exp_stall, exp_flush, exp_flush}, m_stall_cnt, m_flush_cnt);
      end
      clk_adv();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    bus.exe_branch = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_raw_stall();
    test_x0();
    test_flush();
    test_flush_beats_stall();
    test_reload_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
